// File: rtl/zbuf_mem_ctrl.sv
// zbuf_mem_ctrl: z-buffer cache miss service, dirty-tile writeback then 8-word tile fill
module zbuf_mem_ctrl #(
    parameter logic [31:0] ZBUF_BASE  = 32'h0000_0000,
    parameter int          LINE_WORDS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        miss_req,
    input  logic [14:0] miss_block_id,
    input  logic [1:0]  miss_bank,
    input  logic        victim_dirty,
    input  logic [14:0] victim_block_id,
    output logic        busy,
    output logic        miss_done,
    output logic        clean_en,
    output logic [1:0]  clean_bank,
    output logic [4:0]  cache_rd_addr,
    input  logic [31:0] cache_rd_data,
    output logic [4:0]  cache_wr_addr,
    output logic [31:0] cache_wr_data,
    output logic        cache_wr_en,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wr_data,
    output logic        mem_wr_en,
    output logic        mem_rd_en,
    input  logic        mem_ack,
    input  logic [31:0] mem_rd_data,
    input  logic        mem_rd_valid
);
    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] WB_RD     = 3'd1;
    localparam logic [2:0] WB_WR     = 3'd2;
    localparam logic [2:0] FILL_REQ  = 3'd3;
    localparam logic [2:0] FILL_WAIT = 3'd4;
    localparam logic [2:0] DONE      = 3'd5;
    localparam logic [2:0] LAST      = 3'(LINE_WORDS - 1);

    logic [2:0]  state;
    logic [2:0]  idx;
    logic [14:0] blk;
    logic [14:0] vblk;
    logic [1:0]  bank;
    logic [31:0] wdata;
    logic        wb_first;
    logic        last;

    assign last = idx == LAST;

    // sequencer: latch the request in IDLE, walk idx through writeback then fill
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            idx      <= 3'd0;
            blk      <= 15'd0;
            vblk     <= 15'd0;
            bank     <= 2'd0;
            wdata    <= 32'd0;
            wb_first <= 1'b0;
        end else begin
            wb_first <= state == WB_RD;
            if (wb_first)
                wdata <= cache_rd_data;
            case (state)
                IDLE: if (miss_req) begin
                    blk   <= miss_block_id;
                    vblk  <= victim_block_id;
                    bank  <= miss_bank;
                    idx   <= 3'd0;
                    state <= victim_dirty ? WB_RD : FILL_REQ;
                end
                WB_RD: state <= WB_WR;
                WB_WR: if (mem_ack) begin
                    idx   <= last ? 3'd0 : idx + 3'd1;
                    state <= last ? FILL_REQ : WB_RD;
                end
                FILL_REQ: if (mem_ack)
                    state <= FILL_WAIT;
                FILL_WAIT: if (mem_rd_valid) begin
                    idx   <= last ? idx : idx + 3'd1;
                    state <= last ? DONE : FILL_REQ;
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // outputs decoded from state; cache fill and the clean pulse follow the memory handshake directly
    always_comb begin
        busy          = state != IDLE;
        miss_done     = state == DONE;
        mem_wr_en     = state == WB_WR;
        mem_rd_en     = state == FILL_REQ;
        clean_en      = mem_wr_en && mem_ack && last;
        clean_bank    = clean_en ? bank : 2'd0;
        cache_rd_addr = state == WB_RD ? {bank, idx} : 5'd0;
        mem_wr_data   = mem_wr_en ? (wb_first ? cache_rd_data : wdata) : 32'd0;
        mem_addr      = mem_wr_en ? ZBUF_BASE + {12'd0, vblk, idx, 2'b00} :
                        mem_rd_en ? ZBUF_BASE + {12'd0, blk, idx, 2'b00} : 32'd0;
        cache_wr_en   = state == FILL_WAIT && mem_rd_valid;
        cache_wr_addr = cache_wr_en ? {bank, idx} : 5'd0;
        cache_wr_data = cache_wr_en ? mem_rd_data : 32'd0;
    end
endmodule
